// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: accepts one request at a time, aligns it onto a
// beat-wide memory port and returns the lane-extracted, extended load result.
module lsu_mem_ctrl #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [1:0]         req_size_i,
    input  logic               req_unsigned_i,
    input  logic [AW-1:0]      req_addr_i,
    input  logic [XLEN-1:0]    req_wdata_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [XLEN-1:0]    resp_rdata_o,
    output logic               resp_err_o,
    output logic               mem_req_valid_o,
    input  logic               mem_req_ready_i,
    output logic               mem_we_o,
    output logic [AW-1:0]      mem_addr_o,
    output logic [XLEN-1:0]    mem_wdata_o,
    output logic [XLEN/8-1:0]  mem_wstrb_o,
    input  logic               mem_resp_valid_i,
    input  logic [XLEN-1:0]    mem_rdata_i
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("lsu_mem_ctrl: XLEN must be 32 or 64");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [OW-1:0]     off_q;
    logic [AW-1:0]     addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [NB-1:0]     wstrb_q;
    logic              err_q;
    logic [XLEN-1:0]   rdata_q;

    logic [OW-1:0]     req_off;
    logic              req_illegal;
    logic              accept;

    // Misalignment, or a double-word access on a 32-bit datapath.
    function automatic logic access_illegal(input logic [1:0] size, input logic [2:0] lo);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            2'b10:   return |lo[1:0];
            default: return (XLEN == 32) || (|lo);
        endcase
    endfunction

    function automatic logic [NB-1:0] lane_strobe(input logic [1:0] size, input logic [OW-1:0] off);
        logic [15:0] mask;
        mask = (16'd1 << (4'd1 << size)) - 16'd1;
        return NB'(mask << off);
    endfunction

    // Shift the addressed lane down, then sign/zero-extend from the access size.
    // A full-width access has nothing to extend, so req_unsigned_i drops out.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] beat,
                                                   input logic [OW-1:0]   off,
                                                   input logic [1:0]      size,
                                                   input logic            uns);
        logic [63:0] sh;
        logic [63:0] ext;
        sh = 64'(beat) >> {off, 3'b000};
        case (size)
            2'b00:   ext = {{56{sh[7] & ~uns}}, sh[7:0]};
            2'b01:   ext = {{48{sh[15] & ~uns}}, sh[15:0]};
            2'b10:   ext = {{32{sh[31] & ~uns}}, sh[31:0]};
            default: ext = sh;
        endcase
        return XLEN'(ext);
    endfunction

    assign req_off     = req_addr_i[OW-1:0];
    assign req_illegal = access_illegal(req_size_i, req_addr_i[2:0]);
    assign accept      = (state_q == S_IDLE) && req_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        req_ready_o     = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_o      = '0;
        mem_wdata_o     = '0;
        mem_wstrb_o     = '0;
        resp_valid_o    = 1'b0;
        resp_err_o      = 1'b0;
        resp_rdata_o    = '0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = req_illegal ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_we_o        = we_q;
                mem_addr_o      = addr_q;
                mem_wdata_o     = wdata_q;
                mem_wstrb_o     = wstrb_q;
                if (mem_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            // A response arriving with the request handshake is still in S_REQ and is dropped.
            S_WAIT: begin
                if (mem_resp_valid_i) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                resp_err_o   = err_q;
                resp_rdata_o = rdata_q;
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            off_q   <= req_off;
            addr_q  <= req_addr_i & ~AW'(NB - 1);
            wdata_q <= req_we_i ? (req_wdata_i << {req_off, 3'b000}) : '0;
            wstrb_q <= req_we_i ? lane_strobe(req_size_i, req_off) : '0;
            err_q   <= req_illegal;
            rdata_q <= '0;
        end else if (state_q == S_WAIT && mem_resp_valid_i && !we_q) begin
            rdata_q <= load_extend(mem_rdata_i, off_q, size_q, uns_q);
        end
    end

endmodule
